// File: rtl/ctag_pkg.sv
// ctag_pkg: shared constants, FSM state encoding and parity helper for the
// cache tag array sequencer (ctag_ctrl) and its compare unit (ctag_cmp).
//
// Entry layout (ENTRY_W = TAG_W + 2 bits):
//   [CTAG_V]     valid
//   [CTAG_P]     parity (even over {valid, tag})
//   [TAG_W-1:0]  tag
package ctag_pkg;

  localparam int IDX_W   = 10;           // index width, array depth 2**IDX_W
  localparam int TAG_W   = 12;           // tag width
  localparam int ENTRY_W = TAG_W + 2;    // valid + parity + tag
  localparam int CTAG_V  = 13;           // valid bit position
  localparam int CTAG_P  = 12;           // parity bit position

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WSETUP,
    ST_WSTROBE,
    ST_FSETUP,
    ST_FSTROBE
  } state_t;

  // Parity bit that makes {valid, parity, tag} even. An all-zero
  // (invalidated) entry yields 0, so it is parity-consistent.
  function automatic logic ctag_parity(input logic valid,
                                       input logic [TAG_W-1:0] tag);
    return ^{valid, tag};
  endfunction

endpackage

// File: rtl/ctag_cmp.sv
// ctag_cmp: combinational tag compare on the entry read back from the array.
//
// Configuration macro: CTAG_PARITY_EN
//   defined   - parity is checked; an error forces hit = 0, perr = 1
//   undefined - parity bit is ignored; perr is tied 0
//
// Ports:
//   q     in   ENTRY_W  entry read from the array
//   tag   in   TAG_W    tag being looked up
//   hit   out  1        valid & tag match & no parity error
//   perr  out  1        parity error on the entry
module ctag_cmp
  import ctag_pkg::*;
(
  input  logic [ENTRY_W-1:0] q,
  input  logic [TAG_W-1:0]   tag,
  output logic               hit,
  output logic               perr
);

  logic match;

  assign match = q[CTAG_V] && (q[TAG_W-1:0] == tag);

`ifdef CTAG_PARITY_EN
  // The whole entry must carry even parity; a flipped bit anywhere in it,
  // including the parity bit itself, shows up as odd.
  assign perr = ^q;
  assign hit  = match && !perr;
`else
  logic unused_parity;

  assign unused_parity = q[CTAG_P];
  assign perr          = 1'b0;
  assign hit           = match;
`endif

endmodule

// File: rtl/ctag_ctrl.sv
// ctag_ctrl: sequencer for the 1K x 14 cache tag array built from 1K x 1
// asynchronous-read RAMs with an active-low write strobe. Arbitrates flush,
// write (fill / invalidate) and lookup requests onto the single-port array,
// performs the tag compare and drives address, data and nWE. After reset the
// whole array is invalidated by an automatic flush sweep.
//
// Configuration macro: CTAG_PARITY_EN (parity written on fill, checked on
// lookup); undefined by default, in which case parity is written 0.
//
// Ports:
//   CLK, nRESET               clock, asynchronous active-low reset
//   lk_req/lk_idx/lk_tag      lookup request (level, held until lk_ack)
//   lk_ack/lk_hit/lk_perr     1-cycle lookup response
//   wr_req/wr_inv/wr_idx/wr_tag  write request (level, held until wr_ack)
//   wr_ack                    1-cycle write completion
//   flush_req                 start a full-array invalidate sweep
//   flush_busy/flush_done     sweep in progress / 1-cycle completion pulse
//   ram_a/ram_d/ram_nwe       registered array address, data, write strobe
//   ram_q                     array read data (combinational from ram_a)
module ctag_ctrl
  import ctag_pkg::*;
(
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               lk_req,
  input  logic [IDX_W-1:0]   lk_idx,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_ack,
  output logic               lk_hit,
  output logic               lk_perr,
  input  logic               wr_req,
  input  logic               wr_inv,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  output logic               wr_ack,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic [IDX_W-1:0]   ram_a,
  output logic [ENTRY_W-1:0] ram_d,
  input  logic [ENTRY_W-1:0] ram_q,
  output logic               ram_nwe
);

  state_t             state, next_state;
  logic [IDX_W-1:0]   cnt, next_cnt;
  logic [IDX_W-1:0]   next_a;
  logic [ENTRY_W-1:0] next_d;
  logic               next_nwe;
  logic               next_lk_ack, next_lk_hit, next_lk_perr;
  logic               next_wr_ack;
  logic               next_busy, next_done;
  logic               cmp_hit, cmp_perr;
  logic               fill_par;
  logic [ENTRY_W-1:0] fill_d;

  ctag_cmp u_cmp (
    .q    (ram_q),
    .tag  (lk_tag),
    .hit  (cmp_hit),
    .perr (cmp_perr)
  );

`ifdef CTAG_PARITY_EN
  assign fill_par = ctag_parity(1'b1, wr_tag);
`else
  assign fill_par = 1'b0;
`endif

  assign fill_d = {1'b1, fill_par, wr_tag};

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_a       = ram_a;
    next_d       = ram_d;
    next_nwe     = 1'b1;
    next_lk_ack  = 1'b0;
    next_lk_hit  = 1'b0;
    next_lk_perr = 1'b0;
    next_wr_ack  = 1'b0;
    next_busy    = flush_busy;
    next_done    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A requester whose ack is high this cycle is still holding its
        // request for the transaction just completed; skip it once.
        if (flush_req && !flush_done) begin
          next_state = ST_FSETUP;
          next_cnt   = '0;
          next_a     = '0;
          next_d     = '0;
          next_busy  = 1'b1;
        end else if (wr_req && !wr_ack) begin
          next_state = ST_WSETUP;
          next_a     = wr_idx;
          next_d     = wr_inv ? '0 : fill_d;
        end else if (lk_req && !lk_ack) begin
          next_state = ST_LOOKUP;
          next_a     = lk_idx;
        end
      end

      ST_LOOKUP: begin
        next_state   = ST_IDLE;
        next_lk_ack  = 1'b1;
        next_lk_hit  = cmp_hit;
        next_lk_perr = cmp_perr;
      end

      ST_WSETUP: begin
        next_state = ST_WSTROBE;
        next_nwe   = 1'b0;
      end

      ST_WSTROBE: begin
        next_state  = ST_IDLE;
        next_wr_ack = 1'b1;
      end

      ST_FSETUP: begin
        next_state = ST_FSTROBE;
        next_nwe   = 1'b0;
      end

      ST_FSTROBE: begin
        if (cnt == {IDX_W{1'b1}}) begin
          next_state = ST_IDLE;
          next_busy  = 1'b0;
          next_done  = 1'b1;
        end else begin
          // The address advances on the same edge that lifts nWE, so it
          // never moves while the strobe is low.
          next_state = ST_FSETUP;
          next_cnt   = cnt + 1'b1;
          next_a     = cnt + 1'b1;
        end
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  // ram_nwe resets to 1 asynchronously so a reset aborts any strobe at once.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= ST_FSETUP;
      cnt        <= '0;
      ram_a      <= '0;
      ram_d      <= '0;
      ram_nwe    <= 1'b1;
      lk_ack     <= 1'b0;
      lk_hit     <= 1'b0;
      lk_perr    <= 1'b0;
      wr_ack     <= 1'b0;
      flush_busy <= 1'b1;
      flush_done <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      ram_a      <= next_a;
      ram_d      <= next_d;
      ram_nwe    <= next_nwe;
      lk_ack     <= next_lk_ack;
      lk_hit     <= next_lk_hit;
      lk_perr    <= next_lk_perr;
      wr_ack     <= next_wr_ack;
      flush_busy <= next_busy;
      flush_done <= next_done;
    end
  end

endmodule

// File: tb/tb_ctag_ctrl.sv
// tb_ctag_ctrl: directed self-checking bench for ctag_ctrl with a behavioural
// model of the 1K x 14 asynchronous-read tag array.
module tb_ctag_ctrl;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        lk_req = 1'b0;
  logic [9:0]  lk_idx = '0;
  logic [11:0] lk_tag = '0;
  logic        lk_ack, lk_hit, lk_perr;
  logic        wr_req = 1'b0;
  logic        wr_inv = 1'b0;
  logic [9:0]  wr_idx = '0;
  logic [11:0] wr_tag = '0;
  logic        wr_ack;
  logic        flush_req = 1'b0;
  logic        flush_busy, flush_done;
  logic [9:0]  ram_a;
  logic [13:0] ram_d;
  logic [13:0] ram_q;
  logic        ram_nwe;

  int total = 0;
  int bad   = 0;

  // Array model: written at the end of each strobe cycle, read combinationally.
  logic [13:0] mem [1024];
  logic        flip = 1'b0;

  initial for (int i = 0; i < 1024; i++) mem[i] = 14'h3FFF;

  always @(posedge CLK) if (!ram_nwe) mem[ram_a] <= ram_d;

  assign ram_q = mem[ram_a] ^ ((flip && ram_a == 10'h155) ? 14'h1000 : 14'h0000);

  // Bus monitor, sampled on the falling edge.
  int          nwe_lows  = 0;
  int          dirty     = 0;
  int          hold_viol = 0;
  int          done_cnt  = 0;
  logic [9:0]  prev_a = '0;
  logic [13:0] prev_d = '0;

  always @(negedge CLK) begin
    if (nRESET) begin
      if (!ram_nwe) begin
        nwe_lows++;
        if (flush_busy && ram_d != 14'h0) dirty++;
        if (ram_a != prev_a || ram_d != prev_d) hold_viol++;
      end
      if (flush_done) done_cnt++;
    end
    prev_a = ram_a;
    prev_d = ram_d;
  end

  always #5 CLK = ~CLK;

  ctag_ctrl dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .lk_req     (lk_req),
    .lk_idx     (lk_idx),
    .lk_tag     (lk_tag),
    .lk_ack     (lk_ack),
    .lk_hit     (lk_hit),
    .lk_perr    (lk_perr),
    .wr_req     (wr_req),
    .wr_inv     (wr_inv),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_ack     (wr_ack),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_q      (ram_q),
    .ram_nwe    (ram_nwe)
  );

  task automatic test_reset;
    int busy_cycles = 0;
    int lows0, done0, nonzero;
    bit seen = 0;
    repeat (3) @(negedge CLK);
    total++;
    if ({lk_ack, lk_hit, lk_perr, wr_ack, flush_done} !== 5'b0 || ram_a !== 10'h0 ||
        ram_d !== 14'h0 || ram_nwe !== 1'b1 || flush_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: acks=%b a=%h d=%h nwe=%b busy=%b, want 00000 000 0000 1 1",
               {lk_ack, lk_hit, lk_perr, wr_ack, flush_done}, ram_a, ram_d, ram_nwe, flush_busy);
    end
    lows0 = nwe_lows;
    done0 = done_cnt;
    @(posedge CLK);
    #2 nRESET = 1'b1;
    for (int c = 0; c < 2200 && !seen; c++) begin
      @(negedge CLK);
      if (flush_busy) busy_cycles++;
      if (flush_done) seen = 1;
    end
    repeat (4) @(negedge CLK);
    total++;
    if (busy_cycles != 2048) begin
      bad++;
      $display("FAIL reset_sweep_len: busy cycles=%0d, want 2048", busy_cycles);
    end
    total++;
    if (nwe_lows - lows0 != 1024) begin
      bad++;
      $display("FAIL reset_sweep_strobes: nwe low cycles=%0d, want 1024", nwe_lows - lows0);
    end
    total++;
    if (done_cnt - done0 != 1) begin
      bad++;
      $display("FAIL reset_sweep_done: flush_done pulses=%0d, want 1", done_cnt - done0);
    end
    nonzero = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 14'h0) nonzero++;
    total++;
    if (nonzero != 0) begin
      bad++;
      $display("FAIL reset_sweep_clear: nonzero entries=%0d, want 0", nonzero);
    end
  endtask

  task automatic do_write(input logic inv, input logic [9:0] idx, input logic [11:0] tag,
                          input logic [13:0] exp_d, input string nm);
    @(negedge CLK);
    wr_req = 1'b1; wr_inv = inv; wr_idx = idx; wr_tag = tag;
    @(negedge CLK);
    total++;
    if (wr_ack !== 1'b0 || ram_nwe !== 1'b1 || ram_a !== idx) begin
      bad++;
      $display("FAIL %s_setup: wr_ack=%b nwe=%b a=%h, want 0 1 %h", nm, wr_ack, ram_nwe, ram_a, idx);
    end
    @(negedge CLK);
    total++;
    if (ram_nwe !== 1'b0 || ram_d !== exp_d || ram_a !== idx) begin
      bad++;
      $display("FAIL %s_strobe: nwe=%b d=%h a=%h, want 0 %h %h", nm, ram_nwe, ram_d, ram_a, exp_d, idx);
    end
    @(negedge CLK);
    total++;
    if (wr_ack !== 1'b1 || ram_nwe !== 1'b1) begin
      bad++;
      $display("FAIL %s_ack: wr_ack=%b nwe=%b, want 1 1", nm, wr_ack, ram_nwe);
    end
    wr_req = 1'b0;
    @(negedge CLK);
    total++;
    if (wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL %s_ack_pulse: wr_ack=%b, want 0", nm, wr_ack);
    end
  endtask

  task automatic do_lookup(input logic [9:0] idx, input logic [11:0] tag,
                           input logic exp_hit, input logic exp_perr, input string nm);
    @(negedge CLK);
    lk_req = 1'b1; lk_idx = idx; lk_tag = tag;
    @(negedge CLK);
    total++;
    if (lk_ack !== 1'b0) begin
      bad++;
      $display("FAIL %s_early: lk_ack=%b, want 0", nm, lk_ack);
    end
    @(negedge CLK);
    total++;
    if (lk_ack !== 1'b1 || lk_hit !== exp_hit || lk_perr !== exp_perr) begin
      bad++;
      $display("FAIL %s: ack=%b hit=%b perr=%b, want 1 %b %b", nm, lk_ack, lk_hit, lk_perr, exp_hit, exp_perr);
    end
    lk_req = 1'b0;
    @(negedge CLK);
    total++;
    if (lk_ack !== 1'b0) begin
      bad++;
      $display("FAIL %s_ack_pulse: lk_ack=%b, want 0", nm, lk_ack);
    end
  endtask

  task automatic test_fill_lookup;
    do_write(1'b0, 10'h155, 12'hABC, 14'h2ABC, "fill_155");
    do_lookup(10'h155, 12'hABC, 1'b1, 1'b0, "lookup_hit");
    do_lookup(10'h155, 12'hABD, 1'b0, 1'b0, "lookup_tag_miss");
  endtask

  task automatic test_invalidate;
    do_write(1'b1, 10'h155, 12'hABC, 14'h0000, "inval_155");
    do_lookup(10'h155, 12'hABC, 1'b0, 1'b0, "lookup_invalid");
  endtask

  task automatic test_priority;
    int done_c = -1, wr_c = -1, lk_c = -1;
    int nd = 0, nw = 0, nl = 0;
    logic hit_s = 1'b0;
    @(negedge CLK);
    flush_req = 1'b1;
    wr_req = 1'b1; wr_inv = 1'b0; wr_idx = 10'h0AA; wr_tag = 12'h123;
    lk_req = 1'b1; lk_idx = 10'h0AA; lk_tag = 12'h123;
    for (int c = 0; c < 2070; c++) begin
      @(negedge CLK);
      if (flush_done) begin nd++; done_c = c; flush_req = 1'b0; end
      if (wr_ack)     begin nw++; wr_c = c;   wr_req = 1'b0; end
      if (lk_ack)     begin nl++; lk_c = c;   hit_s = lk_hit; lk_req = 1'b0; end
    end
    total++;
    if (nd != 1 || nw != 1 || nl != 1) begin
      bad++;
      $display("FAIL prio_counts: done=%0d wr_ack=%0d lk_ack=%0d, want 1 1 1", nd, nw, nl);
    end
    total++;
    if (done_c != 2048 || wr_c != 2051 || lk_c != 2053) begin
      bad++;
      $display("FAIL prio_order: done@%0d wr@%0d lk@%0d, want 2048 2051 2053", done_c, wr_c, lk_c);
    end
    total++;
    if (hit_s !== 1'b1) begin
      bad++;
      $display("FAIL prio_lookup_hit: hit=%b, want 1", hit_s);
    end
  endtask

  task automatic test_parity;
    do_write(1'b0, 10'h155, 12'hABC, 14'h2ABC, "refill_155");
    flip = 1'b1;
`ifdef CTAG_PARITY_EN
    do_lookup(10'h155, 12'hABC, 1'b0, 1'b1, "lookup_parity_flip");
`else
    do_lookup(10'h155, 12'hABC, 1'b1, 1'b0, "lookup_parity_flip");
`endif
    flip = 1'b0;
  endtask

  task automatic test_reset_mid_sweep;
    bit found = 0;
    bit seen = 0;
    int done0;
    @(negedge CLK);
    flush_req = 1'b1;
    @(negedge CLK);
    flush_req = 1'b0;
    for (int c = 0; c < 1200 && !found; c++) begin
      @(negedge CLK);
      if (ram_a == 10'h200 && !ram_nwe) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midreset_reach: strobe at 0x200 not seen, a=%h", ram_a);
    end
    #1 nRESET = 1'b0;
    #1;
    total++;
    if (ram_nwe !== 1'b1 || flush_busy !== 1'b1 || ram_a !== 10'h0) begin
      bad++;
      $display("FAIL midreset_abort: nwe=%b busy=%b a=%h, want 1 1 000", ram_nwe, flush_busy, ram_a);
    end
    done0 = done_cnt;
    @(posedge CLK);
    #2 nRESET = 1'b1;
    @(negedge CLK);
    total++;
    if (ram_a !== 10'h0 || ram_nwe !== 1'b1 || flush_busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_restart_setup: a=%h nwe=%b busy=%b, want 000 1 1", ram_a, ram_nwe, flush_busy);
    end
    @(negedge CLK);
    total++;
    if (ram_a !== 10'h0 || ram_nwe !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart_strobe: a=%h nwe=%b, want 000 0", ram_a, ram_nwe);
    end
    for (int c = 0; c < 2100 && !seen; c++) begin
      @(negedge CLK);
      if (flush_done) seen = 1;
    end
    repeat (4) @(negedge CLK);
    total++;
    if (done_cnt - done0 != 1 || flush_busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_done: pulses=%0d busy=%b, want 1 0", done_cnt - done0, flush_busy);
    end
  endtask

  initial begin
    test_reset;
    test_fill_lookup;
    test_invalidate;
    test_priority;
    test_parity;
    test_reset_mid_sweep;
    total++;
    if (hold_viol != 0 || dirty != 0) begin
      bad++;
      $display("FAIL bus_rules: addr/data moved under strobe=%0d nonzero flush data=%0d, want 0 0",
               hold_viol, dirty);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
